// File: rtl/decay_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : decay_scheduler
// Purpose  : Walks a table of NUM_NEURONS neurons once per time_step. For each
//            enabled neuron it reads the membrane potential from memory,
//            hands it to an external decay unit, waits for the decayed result
//            (bounded by TIMEOUT cycles) and writes the result back. Disabled
//            neurons are skipped in two cycles with no memory or decay traffic.
// Ports    : clk, rst (async, active-low)
//            time_step            - sweep request
//            cfg_we/addr/mode/en  - per-neuron configuration write
//            mem_rd_en/wr_en/addr/rd_data/wr_data - potential memory
//            dec_load/mode/potential/done/result  - decay unit handshake
//            busy, sweep_done     - status
//            overrun, timeout_err - sticky error flags, cleared by err_clr
// Revision : 1.0 - initial release
// ============================================================================
module decay_scheduler #(
  parameter int NUM_NEURONS = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              time_step,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [2:0]        cfg_mode,
  input  logic              cfg_en,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       mem_wr_data,
  output logic              dec_load,
  output logic [2:0]        dec_mode,
  output logic [31:0]       dec_potential,
  input  logic              dec_done,
  input  logic [31:0]       dec_result,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              err_clr
);

  // Timer only has to count up to TIMEOUT-1.
  localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_RDWAIT = 3'd2,
    S_LOAD   = 3'd3,
    S_WAIT   = 3'd4,
    S_WRITE  = 3'd5,
    S_NEXT   = 3'd6
  } state_t;

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            idx_q, idx_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [31:0]                  pot_q, pot_d;
  logic [31:0]                  res_q, res_d;
  logic [2:0]                   mode_lat_q, mode_lat_d;
  logic                         overrun_q, overrun_d;
  logic                         tmo_q, tmo_d;
  logic [NUM_NEURONS-1:0]       en_q, en_d;
  logic [NUM_NEURONS-1:0][2:0]  mode_q, mode_d;
  logic                         tmo_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      pot_q      <= '0;
      res_q      <= '0;
      mode_lat_q <= '0;
      overrun_q  <= 1'b0;
      tmo_q      <= 1'b0;
      en_q       <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      pot_q      <= pot_d;
      res_q      <= res_d;
      mode_lat_q <= mode_lat_d;
      overrun_q  <= overrun_d;
      tmo_q      <= tmo_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    pot_d       = pot_q;
    res_d       = res_q;
    mode_lat_d  = mode_lat_q;
    en_d        = en_q;
    mode_d      = mode_q;
    tmo_set     = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    dec_load    = 1'b0;
    sweep_done  = 1'b0;

    // Config writes land at any time; the neuron in flight is unaffected
    // because its mode was already copied into mode_lat_q during SCAN.
    if (cfg_we) begin
      en_d[cfg_addr]   = cfg_en;
      mode_d[cfg_addr] = cfg_mode;
    end

    case (state_q)
      S_IDLE: begin
        if (time_step) begin
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (en_q[idx_q]) begin
          mem_rd_en  = 1'b1;
          mem_addr   = idx_q;
          mode_lat_d = mode_q[idx_q];
          state_d    = S_RDWAIT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_RDWAIT: begin
        pot_d   = mem_rd_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        dec_load = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (dec_done) begin
          res_d   = dec_result;
          state_d = S_WRITE;
        end else if (timer_q == TMR_LAST) begin
          // Decay unit never answered: write the original potential back.
          res_d   = pot_q;
          tmo_set = 1'b1;
          state_d = S_WRITE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = idx_q;
        mem_wr_data = res_q;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          sweep_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_comb begin
    overrun_d = (time_step && (state_q != S_IDLE)) || (overrun_q && !err_clr);
    tmo_d     = tmo_set || (tmo_q && !err_clr);
  end

  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;
  assign timeout_err   = tmo_q;
  assign dec_mode      = mode_lat_q;
  // pot_q only changes in RDWAIT, so it is stable from LOAD through WAIT.
  assign dec_potential = pot_q;

endmodule
`default_nettype wire

// File: tb/tb_decay_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_decay_scheduler
// Purpose  : Self-checking bench for decay_scheduler. Behavioural memory and
//            decay-unit responders plus a sweep-level reference model that
//            predicts final memory contents, sweep length and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decay_scheduler;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          time_step = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [2:0]    cfg_mode = '0;
  logic          cfg_en = 1'b0;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rd_data = '0;
  logic [31:0]   mem_wr_data;
  logic          dec_load;
  logic [2:0]    dec_mode;
  logic [31:0]   dec_potential;
  logic          dec_done = 1'b0;
  logic [31:0]   dec_result = '0;
  logic          busy, sweep_done, overrun, timeout_err;
  logic          err_clr = 1'b0;

  decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .time_step(time_step),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
    .dec_load(dec_load), .dec_mode(dec_mode), .dec_potential(dec_potential),
    .dec_done(dec_done), .dec_result(dec_result),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Memory contents, expected contents, shadow config, decay latency per neuron
  // (0 = decay unit never answers).
  logic [31:0] mem     [N];
  logic [31:0] exp_mem [N];
  bit          en_m    [N];
  logic [2:0]  mode_m  [N];
  int          lat_m   [N];

  int total = 0;
  int bad   = 0;
  int n_rd, n_wr, n_ld, n_sd, first_rd;
  int viol_idle = 0;
  int viol_stab = 0;
  bit spur_en = 0;
  bit p_rd = 0, p_wr = 0, p_busy = 0;
  logic [AW-1:0] p_addr = '0;
  int dcnt = 0;
  int cur_n = 0;
  logic [31:0] dpot = '0;
  logic [2:0]  dmode = '0;

  function automatic logic [31:0] decay_f(input logic [31:0] p, input logic [2:0] m);
    return (p >> 1) + 32'(m) - 32'd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; act as memory and decay unit for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    mem_rd_data = p_rd ? mem[p_addr] : $urandom;
    dec_done    = 1'b0;
    dec_result  = $urandom;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        dec_done   = 1'b1;
        dec_result = decay_f(dpot, dec_mode);
      end
    end else if (spur_en && (p_rd || p_wr || !p_busy) && $urandom_range(0, 3) == 0) begin
      dec_done = 1'b1;  // stray pulse in a cycle that cannot be WAIT
    end
    if (!rst) begin
      dcnt     = 0;
      dec_done = 1'b0;
    end
    if (dcnt > 0 && (dec_potential !== dpot || dec_mode !== dmode)) viol_stab++;
    if (!busy && (mem_rd_en || mem_wr_en || dec_load || sweep_done)) viol_idle++;
    if (mem_rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = int'(mem_addr);
      cur_n = int'(mem_addr);
    end
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wr_data;
      n_wr++;
    end
    if (dec_load) begin
      n_ld++;
      dpot  = dec_potential;
      dmode = dec_mode;
      dcnt  = lat_m[cur_n];
    end
    if (sweep_done) n_sd++;
    p_rd = mem_rd_en; p_wr = mem_wr_en; p_busy = busy; p_addr = mem_addr;
  endtask

  task automatic cfg_write(input int a, input bit e, input logic [2:0] m);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_en = e; cfg_mode = m;
    step();
    cfg_we = 1'b0;
    en_m[a] = e; mode_m[a] = m;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  // Sweep-level model: cost per neuron and final memory image.
  task automatic predict(output int cyc, output bit to, output int nen);
    cyc = 0; to = 0; nen = 0;
    for (int i = 0; i < N; i++) begin
      exp_mem[i] = mem[i];
      if (en_m[i]) begin
        nen++;
        if (lat_m[i] != 0 && lat_m[i] <= TO) begin
          cyc += 5 + lat_m[i];
          exp_mem[i] = decay_f(mem[i], mode_m[i]);
        end else begin
          cyc += 5 + TO;
          to = 1;
        end
      end else begin
        cyc += 2;
      end
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) d++;
    return d;
  endfunction

  // Returns cycles from the time_step cycle to the sweep_done cycle.
  task automatic run_sweep(input int ovr_at, input int clr_at, input int cfg_at,
                           input int cfg_a, input logic [2:0] cfg_m, output int k);
    n_rd = 0; n_wr = 0; n_ld = 0; n_sd = 0; first_rd = -1;
    time_step = 1'b1; step(); time_step = 1'b0;
    k = 1;
    while (!sweep_done && k < 4000) begin
      time_step = (k == ovr_at);
      err_clr   = (k == clr_at);
      if (k == cfg_at) begin
        cfg_we = 1'b1; cfg_addr = AW'(cfg_a); cfg_mode = cfg_m; cfg_en = 1'b1;
      end
      step();
      k++;
      time_step = 1'b0; err_clr = 1'b0; cfg_we = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, ecyc, nen, k;
    bit  eto, seen;
    logic [31:0] keep;
    for (int i = 0; i < N; i++) begin
      mem[i] = '0; en_m[i] = 0; mode_m[i] = '0; lat_m[i] = 1;
    end

    // ---- reset state
    rst = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_dec_load", dec_load, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_outputs", {mem_addr, dec_mode}, 0);
    chk("rst_dec_pot", dec_potential, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    rst = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // ---- two enabled neurons, decay = input>>1 after 3 cycles
    cfg_write(0, 1, 3'd2); cfg_write(1, 1, 3'd2);
    mem[0] = 32'h100; mem[1] = 32'h40; lat_m[0] = 3; lat_m[1] = 3;
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("basic_cycles", 32'(cyc), 32'd76);
    chk("basic_mem0", mem[0], 32'h80);
    chk("basic_mem1", mem[1], 32'h20);
    chk("basic_writes", 32'(n_wr), 32'd2);
    chk("basic_sd_pulses", 32'(n_sd), 32'd1);
    step();
    chk("basic_busy_after", busy, 0);
    chk("basic_sd_after", sweep_done, 0);

    // ---- all disabled
    cfg_write(0, 0, 3'd0); cfg_write(1, 0, 3'd0);
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("dis_cycles", 32'(cyc), 32'(2 * N));
    chk("dis_traffic", 32'(n_rd + n_wr + n_ld), 32'd0);
    step();

    // ---- neuron 5 with a silent decay unit
    cfg_write(5, 1, 3'd3); lat_m[5] = 0; mem[5] = 32'hDEADBEEF;
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("tmo_cycles", 32'(cyc), 32'(2 * (N - 1) + 5 + TO));
    chk("tmo_mem5", mem[5], 32'hDEADBEEF);
    chk("tmo_writes", 32'(n_wr), 32'd1);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_no_overrun", overrun, 0);
    step();
    pulse_clr();
    chk("tmo_cleared", timeout_err, 0);

    // ---- timeout boundary: answer on the last WAIT cycle vs one cycle late
    cfg_write(6, 1, 3'd4); lat_m[5] = TO; lat_m[6] = TO + 1;
    mem[5] = 32'h1234; mem[6] = 32'h5678;
    predict(ecyc, eto, nen);
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("bnd_cycles", 32'(cyc), 32'(ecyc));
    chk("bnd_mem", 32'(mem_diffs()), 32'd0);
    chk("bnd_flag", timeout_err, 32'(eto));
    step();
    cfg_write(5, 0, 3'd0); cfg_write(6, 0, 3'd0);
    pulse_clr();

    // ---- overrun during WAIT, then simultaneous set and clear
    cfg_write(0, 1, 3'd1); lat_m[0] = 5; mem[0] = 32'h2000;
    predict(ecyc, eto, nen);
    run_sweep(5, -1, -1, 0, 3'd0, cyc);
    chk("ovr_cycles", 32'(cyc), 32'(ecyc));
    chk("ovr_mem", 32'(mem_diffs()), 32'd0);
    chk("ovr_flag", overrun, 1);
    seen = 0;
    repeat (4) begin step(); seen |= busy; end
    chk("ovr_no_second_sweep", 32'(seen), 32'd0);
    pulse_clr();
    chk("ovr_cleared", overrun, 0);
    predict(ecyc, eto, nen);
    run_sweep(2, 2, -1, 0, 3'd0, cyc);
    chk("ovr2_first_idx", 32'(first_rd), 32'd0);
    chk("ovr2_set_wins", overrun, 1);
    chk("ovr2_mem", 32'(mem_diffs()), 32'd0);
    step();
    cfg_write(0, 0, 3'd0);
    pulse_clr();

    // ---- reset in WAIT of neuron 3
    cfg_write(3, 1, 3'd6); lat_m[3] = 0; mem[3] = 32'hCAFE0003;
    n_wr = 0;
    time_step = 1'b1; step(); time_step = 1'b0;
    k = 0;
    while (!dec_load && k < 200) begin step(); k++; end
    chk("rstw_reached_load", dec_load, 1);
    repeat (4) step();
    rst = 1'b0;
    #1;
    chk("rstw_busy_async", busy, 0);
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin en_m[i] = 0; mode_m[i] = '0; end
    chk("rstw_no_write", 32'(n_wr), 32'd0);
    chk("rstw_mem3", mem[3], 32'hCAFE0003);
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("rstw_cleared_table", 32'(n_rd + n_wr + n_ld), 32'd0);
    chk("rstw_cycles", 32'(cyc), 32'(2 * N));
    step();

    // ---- cfg write to the neuron in flight
    cfg_write(2, 1, 3'd1); lat_m[2] = 4; mem[2] = 32'h1000;
    predict(ecyc, eto, nen);
    keep = exp_mem[2];
    run_sweep(-1, -1, 9, 2, 3'd5, cyc);
    mode_m[2] = 3'd5;
    chk("inflight_cycles", 32'(cyc), 32'(ecyc));
    chk("inflight_mem2", mem[2], keep);
    step();
    predict(ecyc, eto, nen);
    run_sweep(-1, -1, -1, 0, 3'd0, cyc);
    chk("newmode_mem", 32'(mem_diffs()), 32'd0);
    step();

    // ---- randomized sweeps
    spur_en = 1;
    for (int s = 0; s < 6; s++) begin
      int ovr;
      for (int i = 0; i < N; i++) begin
        cfg_write(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        lat_m[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
        mem[i]   = $urandom;
      end
      ovr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
      pulse_clr();
      predict(ecyc, eto, nen);
      run_sweep(ovr, -1, -1, 0, 3'd0, cyc);
      chk("rnd_cycles", 32'(cyc), 32'(ecyc));
      chk("rnd_mem", 32'(mem_diffs()), 32'd0);
      chk("rnd_timeout", timeout_err, 32'(eto));
      chk("rnd_overrun", overrun, 32'(ovr > 0));
      chk("rnd_writes", 32'(n_wr), 32'(nen));
      chk("rnd_loads", 32'(n_ld), 32'(nen));
      step();
    end

    chk("idle_quiet", 32'(viol_idle), 32'd0);
    chk("decay_inputs_stable", 32'(viol_stab), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
